// File: rtl/fde_pipe_if.sv
// rtl/fde_pipe_if.sv - fetch/decode/execute front-end port bundle
interface fde_pipe_if #(
    parameter int XLEN = 32
);
    logic            fetch_en;
    logic [XLEN-1:0] pc;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            may_jump;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rd;
    logic            ex_rd_we;
    logic [XLEN-1:0] ex_result;
    logic            ex_is_jump;
    logic [XLEN-1:0] ex_jump_dest;

    // Core control / memory / register-file side
    modport master (
        output fetch_en, pc, stall, flush, imem_rdata, rs1_val, rs2_val,
        input  imem_addr, rs1_addr, rs2_addr, may_jump,
        input  ex_valid, ex_pc, ex_rd, ex_rd_we, ex_result, ex_is_jump, ex_jump_dest
    );

    // Pipeline side
    modport slave (
        input  fetch_en, pc, stall, flush, imem_rdata, rs1_val, rs2_val,
        output imem_addr, rs1_addr, rs2_addr, may_jump,
        output ex_valid, ex_pc, ex_rd, ex_rd_we, ex_result, ex_is_jump, ex_jump_dest
    );
endinterface

// File: rtl/fde_pipe.sv
// rtl/fde_pipe.sv - three-stage RV32I fetch/decode/execute front end
module fde_pipe #(
    parameter int              XLEN   = 32,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic       clk,
    input  logic       rstn,
    fde_pipe_if.slave  bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Fetch stage
    logic            f_valid;
    logic [XLEN-1:0] f_pc;
    logic [31:0]     f_instr;
    logic [XLEN-1:0] f_imm;
    logic            f_is_ctrl;

    // Decode stage; d_alt is instr[30] (funct7[5] for OP, imm[10] for SRAI)
    logic            d_valid;
    logic            d_may_jump;
    logic            d_alt;
    logic [6:0]      d_opcode;
    logic [2:0]      d_funct3;
    logic [4:0]      d_rd;
    logic [XLEN-1:0] d_pc;
    logic [XLEN-1:0] d_imm;
    logic [XLEN-1:0] d_rs1v;
    logic [XLEN-1:0] d_rs2v;

    // Execute stage
    logic            ex_valid;
    logic            ex_rd_we;
    logic            ex_is_jump;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] ex_jump_dest;

    // Execute next-state
    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] imm_w;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] alu_out;
    logic            br_take;
    logic [XLEN-1:0] n_result;
    logic [XLEN-1:0] n_target;
    logic            n_rd_we;
    logic            n_taken;

    assign bus.imem_addr    = bus.pc;
    assign bus.rs1_addr     = f_instr[19:15];
    assign bus.rs2_addr     = f_instr[24:20];
    assign bus.may_jump     = d_may_jump;
    assign bus.ex_valid     = ex_valid;
    assign bus.ex_pc        = ex_pc;
    assign bus.ex_rd        = ex_rd;
    assign bus.ex_rd_we     = ex_rd_we;
    assign bus.ex_result    = ex_result;
    assign bus.ex_is_jump   = ex_is_jump;
    assign bus.ex_jump_dest = ex_jump_dest;

    // Immediate extraction for the fetched instruction, chosen by format
    always_comb begin
        f_imm     = '0;
        f_is_ctrl = 1'b0;
        case (f_instr[6:0])
            OPC_OPIMM, OPC_LOAD: f_imm = {{20{f_instr[31]}}, f_instr[31:20]};
            OPC_JALR: begin
                f_imm     = {{20{f_instr[31]}}, f_instr[31:20]};
                f_is_ctrl = 1'b1;
            end
            OPC_STORE: f_imm = {{20{f_instr[31]}}, f_instr[31:25], f_instr[11:7]};
            OPC_BRANCH: begin
                f_imm     = {{19{f_instr[31]}}, f_instr[31], f_instr[7],
                             f_instr[30:25], f_instr[11:8], 1'b0};
                f_is_ctrl = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: f_imm = {f_instr[31:12], 12'b0};
            OPC_JAL: begin
                f_imm     = {{11{f_instr[31]}}, f_instr[31], f_instr[19:12],
                             f_instr[20], f_instr[30:21], 1'b0};
                f_is_ctrl = 1'b1;
            end
            default: f_imm = '0;
        endcase
    end

    // ALU, branch compare and per-opcode result/target selection
    always_comb begin
        op_b   = (d_opcode == OPC_OP) ? d_rs2v : d_imm;
        shamt  = op_b[4:0];
        // Byte offsets become word offsets; shift must stay arithmetic
        imm_w  = $unsigned($signed(d_imm) >>> 2);
        pc_inc = d_pc + XLEN'(1);

        case (d_funct3)
            3'd0:    alu_out = (d_opcode == OPC_OP && d_alt) ? d_rs1v - op_b : d_rs1v + op_b;
            3'd1:    alu_out = d_rs1v << shamt;
            3'd2:    alu_out = {{(XLEN-1){1'b0}}, ($signed(d_rs1v) < $signed(op_b))};
            3'd3:    alu_out = {{(XLEN-1){1'b0}}, (d_rs1v < op_b)};
            3'd4:    alu_out = d_rs1v ^ op_b;
            3'd5:    alu_out = d_alt ? $unsigned($signed(d_rs1v) >>> shamt) : d_rs1v >> shamt;
            3'd6:    alu_out = d_rs1v | op_b;
            default: alu_out = d_rs1v & op_b;
        endcase

        case (d_funct3)
            3'd0:    br_take = (d_rs1v == d_rs2v);
            3'd1:    br_take = (d_rs1v != d_rs2v);
            3'd4:    br_take = ($signed(d_rs1v) < $signed(d_rs2v));
            3'd5:    br_take = ($signed(d_rs1v) >= $signed(d_rs2v));
            3'd6:    br_take = (d_rs1v < d_rs2v);
            3'd7:    br_take = (d_rs1v >= d_rs2v);
            default: br_take = 1'b0;
        endcase

        n_result = '0;
        n_target = pc_inc;
        n_rd_we  = 1'b0;
        n_taken  = 1'b0;
        case (d_opcode)
            OPC_LUI:   begin n_result = d_imm;          n_rd_we = 1'b1; end
            OPC_AUIPC: begin n_result = d_pc + imm_w;   n_rd_we = 1'b1; end
            OPC_JAL: begin
                n_result = pc_inc;  n_rd_we = 1'b1;
                n_taken  = 1'b1;    n_target = d_pc + imm_w;
            end
            OPC_JALR: begin
                n_result = pc_inc;  n_rd_we = 1'b1;
                n_taken  = 1'b1;    n_target = d_rs1v + d_imm;
            end
            OPC_BRANCH: begin n_taken = br_take; n_target = d_pc + imm_w; end
            OPC_OP, OPC_OPIMM: begin n_result = alu_out; n_rd_we = 1'b1; end
            OPC_LOAD:  begin n_result = d_rs1v + d_imm; n_rd_we = 1'b1; end
            OPC_STORE: n_result = d_rs1v + d_imm;
            default:   n_result = '0;
        endcase
        n_rd_we = n_rd_we & d_valid & (d_rd != 5'd0);
        n_taken = n_taken & d_valid;
    end

    // Fetch register: capture pc and instruction word unless stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_valid <= 1'b0;
            f_pc    <= RST_PC;
            f_instr <= '0;
        end else if (!bus.stall) begin
            f_valid <= bus.fetch_en & ~bus.flush;
            f_pc    <= bus.pc;
            f_instr <= bus.imem_rdata;
        end
    end

    // Decode register: fields, immediate and register-file operands
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_valid    <= 1'b0;
            d_may_jump <= 1'b0;
            d_alt      <= 1'b0;
            d_opcode   <= '0;
            d_funct3   <= '0;
            d_rd       <= '0;
            d_pc       <= RST_PC;
            d_imm      <= '0;
            d_rs1v     <= '0;
            d_rs2v     <= '0;
        end else if (!bus.stall) begin
            d_valid    <= f_valid & ~bus.flush;
            d_may_jump <= f_valid & ~bus.flush & f_is_ctrl;
            d_alt      <= f_instr[30];
            d_opcode   <= f_instr[6:0];
            d_funct3   <= f_instr[14:12];
            d_rd       <= f_instr[11:7];
            d_pc       <= f_pc;
            d_imm      <= f_imm;
            d_rs1v     <= bus.rs1_val;
            d_rs2v     <= bus.rs2_val;
        end
    end

    // Execute register: flush never reaches this stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid     <= 1'b0;
            ex_rd_we     <= 1'b0;
            ex_is_jump   <= 1'b0;
            ex_rd        <= '0;
            ex_pc        <= RST_PC;
            ex_result    <= '0;
            ex_jump_dest <= '0;
        end else if (!bus.stall) begin
            ex_valid     <= d_valid;
            ex_rd_we     <= n_rd_we;
            ex_is_jump   <= n_taken;
            ex_rd        <= d_rd;
            ex_pc        <= d_pc;
            ex_result    <= n_result;
            ex_jump_dest <= n_taken ? n_target : pc_inc;
        end
    end
endmodule

// File: tb/tb_fde_pipe.sv
// tb/tb_fde_pipe.sv - directed self-checking bench for fde_pipe
module tb_fde_pipe;
    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    fde_pipe_if bus ();

    fde_pipe dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Fetch one instruction, supply operands while it sits in fetch, run to execute
    task automatic run1(input logic [31:0] p, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b);
        bus.fetch_en   = 1'b1;
        bus.pc         = p;
        bus.imem_rdata = ins;
        tick();
        bus.fetch_en   = 1'b0;
        bus.rs1_val    = a;
        bus.rs2_val    = b;
        tick();
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        bus.fetch_en = 1'b0; bus.pc = '0; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.imem_rdata = '0; bus.rs1_val = '0; bus.rs2_val = '0;
        tick(); tick();
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_may_jump", bus.may_jump, 0);
        chk("rst_ex_pc", bus.ex_pc, 0);
        chk("rst_ex_result", bus.ex_result, 0);
        chk("rst_ex_rd_we", bus.ex_rd_we, 0);
        chk("rst_ex_is_jump", bus.ex_is_jump, 0);
        chk("rst_ex_jump_dest", bus.ex_jump_dest, 0);
        rstn = 1'b1;
        tick();

        // addi x1,x0,5 at pc 0
        run1(32'd0, 32'h00500093, 32'd0, 32'd0);
        chk("addi_valid", bus.ex_valid, 1);
        chk("addi_rd", bus.ex_rd, 1);
        chk("addi_we", bus.ex_rd_we, 1);
        chk("addi_result", bus.ex_result, 5);
        chk("addi_is_jump", bus.ex_is_jump, 0);
        chk("addi_dest", bus.ex_jump_dest, 1);
        chk("addi_pc", bus.ex_pc, 0);
        tick();
        chk("drain_valid", bus.ex_valid, 0);

        // add x3,x1,x2 with wrap; also imem_addr and rs addresses
        bus.fetch_en = 1'b1; bus.pc = 32'd1; bus.imem_rdata = 32'h002081B3;
        #1;
        chk("imem_addr", bus.imem_addr, 1);
        tick();
        bus.fetch_en = 1'b0;
        chk("add_rs1_addr", bus.rs1_addr, 1);
        chk("add_rs2_addr", bus.rs2_addr, 2);
        bus.rs1_val = 32'd7; bus.rs2_val = 32'hFFFFFFFF;
        tick();
        chk("add_ex_early", bus.ex_valid, 0);
        tick();
        chk("add_result", bus.ex_result, 6);
        chk("add_rd", bus.ex_rd, 3);
        chk("add_dest", bus.ex_jump_dest, 2);

        // beq x1,x2,+8 at pc 4, equal operands
        bus.fetch_en = 1'b1; bus.pc = 32'd4; bus.imem_rdata = 32'h00208463;
        tick();
        bus.fetch_en = 1'b0; bus.rs1_val = 32'd9; bus.rs2_val = 32'd9;
        tick();
        chk("beq_may_jump", bus.may_jump, 1);
        tick();
        chk("beq_eq_jump", bus.ex_is_jump, 1);
        chk("beq_eq_dest", bus.ex_jump_dest, 6);
        chk("beq_we", bus.ex_rd_we, 0);
        tick();
        chk("beq_idle_jump", bus.ex_is_jump, 0);

        // beq unequal operands
        run1(32'd4, 32'h00208463, 32'd9, 32'd10);
        chk("beq_ne_jump", bus.ex_is_jump, 0);
        chk("beq_ne_dest", bus.ex_jump_dest, 5);

        // jal x1,+16 at pc 10
        run1(32'd10, 32'h010000EF, 32'd0, 32'd0);
        chk("jal_jump", bus.ex_is_jump, 1);
        chk("jal_dest", bus.ex_jump_dest, 14);
        chk("jal_result", bus.ex_result, 11);
        chk("jal_rd", bus.ex_rd, 1);

        // jalr x5,4(x6) at pc 20, rs1=100
        run1(32'd20, 32'h004302E7, 32'd100, 32'd0);
        chk("jalr_dest", bus.ex_jump_dest, 104);
        chk("jalr_result", bus.ex_result, 21);

        // sra x4,x1,x2 of negative value
        run1(32'd21, 32'h4020D233, 32'h80000000, 32'd4);
        chk("sra_result", bus.ex_result, 32'hF8000000);

        // auipc x8,0xFFFFF at pc 8 (negative word offset)
        run1(32'd8, 32'hFFFFF417, 32'd0, 32'd0);
        chk("auipc_result", bus.ex_result, 32'hFFFFFC08);
        chk("auipc_rd", bus.ex_rd, 8);

        // sw x2,-4(x1): effective address, no write
        run1(32'd22, 32'hFE20AE23, 32'd100, 32'd0);
        chk("sw_result", bus.ex_result, 96);
        chk("sw_we", bus.ex_rd_we, 0);

        // addi x0,x0,5: rd==0 forces no write
        run1(32'd23, 32'h00500013, 32'd0, 32'd0);
        chk("x0_result", bus.ex_result, 5);
        chk("x0_we", bus.ex_rd_we, 0);

        // unknown opcode
        run1(32'd24, 32'h00000FFF, 32'd3, 32'd4);
        chk("unk_valid", bus.ex_valid, 1);
        chk("unk_we", bus.ex_rd_we, 0);
        chk("unk_jump", bus.ex_is_jump, 0);
        chk("unk_result", bus.ex_result, 0);

        // back-to-back stream, flush at the third fetch edge
        bus.rs1_val = '0; bus.rs2_val = '0;
        bus.fetch_en = 1'b1; bus.pc = 32'd0; bus.imem_rdata = 32'h00100093;
        tick();
        bus.pc = 32'd1; bus.imem_rdata = 32'h00200113;
        tick();
        bus.pc = 32'd2; bus.imem_rdata = 32'h00300193; bus.flush = 1'b1;
        tick();
        chk("flush_i0_valid", bus.ex_valid, 1);
        chk("flush_i0_rd", bus.ex_rd, 1);
        chk("flush_i0_result", bus.ex_result, 1);
        bus.flush = 1'b0; bus.pc = 32'd3; bus.imem_rdata = 32'h00400213;
        tick();
        bus.fetch_en = 1'b0;
        chk("flush_i1_killed", bus.ex_valid, 0);
        tick();
        chk("flush_i2_killed", bus.ex_valid, 0);
        tick();
        chk("redirect_valid", bus.ex_valid, 1);
        chk("redirect_rd", bus.ex_rd, 4);
        chk("redirect_pc", bus.ex_pc, 3);

        // stall for 2 cycles (with flush too) freezes execute and decode
        bus.fetch_en = 1'b1; bus.pc = 32'd30; bus.imem_rdata = 32'h00900293;
        tick();
        bus.pc = 32'd31; bus.imem_rdata = 32'h00600313;
        tick();
        bus.fetch_en = 1'b0;
        tick();
        bus.stall = 1'b1; bus.flush = 1'b1; bus.fetch_en = 1'b1;
        bus.pc = 32'd50; bus.imem_rdata = 32'h00100093;
        tick(); tick();
        chk("stall_valid", bus.ex_valid, 1);
        chk("stall_rd", bus.ex_rd, 5);
        chk("stall_result", bus.ex_result, 9);
        chk("stall_pc", bus.ex_pc, 30);
        chk("stall_dest", bus.ex_jump_dest, 31);
        chk("stall_we", bus.ex_rd_we, 1);
        bus.stall = 1'b0; bus.flush = 1'b0; bus.fetch_en = 1'b0;
        tick();
        chk("unstall_rd", bus.ex_rd, 6);
        chk("unstall_result", bus.ex_result, 6);
        chk("unstall_pc", bus.ex_pc, 31);
        tick(); tick();

        // reset with three instructions in flight
        bus.fetch_en = 1'b1; bus.pc = 32'd0; bus.imem_rdata = 32'h00100093;
        tick();
        bus.pc = 32'd4; bus.imem_rdata = 32'h00208463;
        tick();
        bus.pc = 32'd5; bus.imem_rdata = 32'h002081B3;
        tick();
        chk("pre_rst_may_jump", bus.may_jump, 1);
        chk("pre_rst_valid", bus.ex_valid, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", bus.ex_valid, 0);
        chk("mid_rst_may_jump", bus.may_jump, 0);
        chk("mid_rst_result", bus.ex_result, 0);
        chk("mid_rst_rd", bus.ex_rd, 0);
        chk("mid_rst_rs1_addr", bus.rs1_addr, 0);
        bus.fetch_en = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        bus.fetch_en = 1'b1; bus.pc = 32'd40; bus.imem_rdata = 32'h00700393;
        tick();
        bus.fetch_en = 1'b0;
        tick();
        chk("post_rst_early", bus.ex_valid, 0);
        tick();
        chk("post_rst_valid", bus.ex_valid, 1);
        chk("post_rst_rd", bus.ex_rd, 7);
        chk("post_rst_result", bus.ex_result, 7);
        chk("post_rst_pc", bus.ex_pc, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
